// File: rtl/gauss5_pkg.sv
// -----------------------------------------------------------------------------
// gauss5_pkg
// Shared constants for the 5x5 Gaussian filter:
//   K0..K4      separable kernel taps 1,4,6,4,1 (2-D weight sum 256)
//   KSUM_SHIFT  normalisation shift (log2 of the 2-D weight sum)
//   PIX_W       pixel width
//   HSUM_W      width of one horizontal (row) weighted sum
//   VSUM_W      width of the vertical weighted sum of the row sums
//   ROUND_BIAS  half-LSB bias added before the normalising shift when
//               the GAUSS_ROUND_EN build option is defined
// -----------------------------------------------------------------------------
package gauss5_pkg;

    localparam int K0 = 1;
    localparam int K1 = 4;
    localparam int K2 = 6;
    localparam int K3 = 4;
    localparam int K4 = 1;

    localparam int KSUM_SHIFT = 8;

    localparam int PIX_W  = 8;
    localparam int HSUM_W = 12;
    localparam int VSUM_W = 16;

    localparam int ROUND_BIAS = 128;

endpackage

// File: rtl/gauss5_tap_sum.sv
// -----------------------------------------------------------------------------
// gauss5_tap_sum
// Combinational 1-4-6-4-1 weighted sum of five unsigned samples, built from
// shifts and adds only. The output is IN_W+4 bits wide, which holds the
// worst case of 16 * (2**IN_W - 1).
// Ports:
//   a..e  in   IN_W     samples, a and e carry weight 1, c carries weight 6
//   sum   out  IN_W+4   weighted sum
// -----------------------------------------------------------------------------
module gauss5_tap_sum
    import gauss5_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
    input  logic [IN_W-1:0]   c,
    input  logic [IN_W-1:0]   d,
    input  logic [IN_W-1:0]   e,
    output logic [IN_W+3:0]   sum
);

    localparam int OUT_W = IN_W + 4;

    // Each tap weight is a power of two except the centre (6 = 4 + 2),
    // so every term is one or two shifted copies of the sample.
    localparam int SH0  = $clog2(K0);
    localparam int SH1  = $clog2(K1);
    localparam int SH2A = $clog2(K2 - 2);
    localparam int SH2B = $clog2(K2 - 4);
    localparam int SH3  = $clog2(K3);
    localparam int SH4  = $clog2(K4);

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] c_ext;
    logic [OUT_W-1:0] d_ext;
    logic [OUT_W-1:0] e_ext;

    assign a_ext = OUT_W'(a);
    assign b_ext = OUT_W'(b);
    assign c_ext = OUT_W'(c);
    assign d_ext = OUT_W'(d);
    assign e_ext = OUT_W'(e);

    assign sum = (a_ext << SH0)
               + (b_ext << SH1)
               + (c_ext << SH2A) + (c_ext << SH2B)
               + (d_ext << SH3)
               + (e_ext << SH4);

endmodule

// File: rtl/gaussian_filter_5x5.sv
// -----------------------------------------------------------------------------
// gaussian_filter_5x5
// Three-stage separable 5x5 Gaussian blur (kernel 1,4,6,4,1 outer product).
//   S1: five row sums          S2: vertical sum of row sums
//   S3: normalise to 8 bits (truncate, or round half up when the
//       GAUSS_ROUND_EN macro is defined)
// A frame counter flags the last of every ROWS*COLS output pixels.
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous reset, active low
//   d0_i..d24_i   in   8   window pixels, row-major, d12 is the centre
//   done_i        in   1   window valid
//   pixel_o       out  8   filtered pixel, holds between valid outputs
//   done_o        out  1   pixel_o valid (done_i delayed three cycles)
//   frame_done_o  out  1   pulse with the last done_o of a frame
// Build option: GAUSS_ROUND_EN selects round-half-up normalisation.
// -----------------------------------------------------------------------------
module gaussian_filter_5x5
    import gauss5_pkg::*;
#(
    parameter int ROWS = 7,
    parameter int COLS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d0_i,  input logic [7:0] d1_i,  input logic [7:0] d2_i,
    input  logic [7:0]       d3_i,  input logic [7:0] d4_i,  input logic [7:0] d5_i,
    input  logic [7:0]       d6_i,  input logic [7:0] d7_i,  input logic [7:0] d8_i,
    input  logic [7:0]       d9_i,  input logic [7:0] d10_i, input logic [7:0] d11_i,
    input  logic [7:0]       d12_i, input logic [7:0] d13_i, input logic [7:0] d14_i,
    input  logic [7:0]       d15_i, input logic [7:0] d16_i, input logic [7:0] d17_i,
    input  logic [7:0]       d18_i, input logic [7:0] d19_i, input logic [7:0] d20_i,
    input  logic [7:0]       d21_i, input logic [7:0] d22_i, input logic [7:0] d23_i,
    input  logic [7:0]       d24_i,
    input  logic             done_i,
    output logic [7:0]       pixel_o,
    output logic             done_o,
    output logic             frame_done_o
);

    localparam int FRAME = ROWS * COLS;
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    logic [PIX_W-1:0]  win [25];
    logic [HSUM_W-1:0] h_next [5];
    logic [HSUM_W-1:0] h_reg  [5];
    logic [VSUM_W-1:0] v_next;
    logic [VSUM_W-1:0] v_reg;
    logic [PIX_W-1:0]  pixel_next;
    logic [PIX_W-1:0]  pixel_reg;
    logic              v1_reg, v2_reg, v3_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              last_pix;

    assign win = '{d0_i,  d1_i,  d2_i,  d3_i,  d4_i,
                   d5_i,  d6_i,  d7_i,  d8_i,  d9_i,
                   d10_i, d11_i, d12_i, d13_i, d14_i,
                   d15_i, d16_i, d17_i, d18_i, d19_i,
                   d20_i, d21_i, d22_i, d23_i, d24_i};

    // S1: one horizontal tap sum per window row.
    for (genvar gi = 0; gi < 5; gi++) begin : g_row
        gauss5_tap_sum #(.IN_W(PIX_W)) u_row_sum (
            .a   (win[5*gi + 0]),
            .b   (win[5*gi + 1]),
            .c   (win[5*gi + 2]),
            .d   (win[5*gi + 3]),
            .e   (win[5*gi + 4]),
            .sum (h_next[gi])
        );
    end

    // S2: vertical tap sum over the registered row sums.
    gauss5_tap_sum #(.IN_W(HSUM_W)) u_col_sum (
        .a   (h_reg[0]),
        .b   (h_reg[1]),
        .c   (h_reg[2]),
        .d   (h_reg[3]),
        .e   (h_reg[4]),
        .sum (v_next)
    );

    // S3: normalise by the kernel weight sum. The result is at most 255,
    // and the biased sum at most 65408, so no saturation is needed.
`ifdef GAUSS_ROUND_EN
    assign pixel_next = PIX_W'((v_reg + VSUM_W'(ROUND_BIAS)) >> KSUM_SHIFT);
`else
    assign pixel_next = PIX_W'(v_reg >> KSUM_SHIFT);
`endif

    assign last_pix = (count_reg == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                h_reg[i] <= '0;
            end
            v_reg     <= '0;
            pixel_reg <= '0;
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            v3_reg    <= 1'b0;
            count_reg <= '0;
        end else begin
            v1_reg <= done_i;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;

            // Data registers only advance behind a valid, so bubbles leave
            // every stage (and therefore pixel_o) holding its last result.
            if (done_i) begin
                h_reg <= h_next;
            end
            if (v1_reg) begin
                v_reg <= v_next;
            end
            if (v2_reg) begin
                pixel_reg <= pixel_next;
            end

            if (v3_reg) begin
                count_reg <= last_pix ? '0 : count_reg + 1'b1;
            end
        end
    end

    assign pixel_o      = pixel_reg;
    assign done_o       = v3_reg;
    assign frame_done_o = v3_reg & last_pix;

endmodule

// File: tb/tb_gaussian_filter_5x5.sv
module tb_gaussian_filter_5x5;

    localparam int FRAME = 7 * 7;

    typedef logic [7:0] win_t [25];

    typedef struct {
        int fill;
        int poke_idx;
        int poke_val;
        int exp_pix;
        string name;
    } vec_t;

    typedef struct {
        bit vld;
        int pix;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       done_i;
    win_t       win;
    logic [7:0] pixel_o;
    logic       done_o;
    logic       frame_done_o;

    int   total = 0;
    int   bad   = 0;
    int   out_cnt  = 0;
    int   last_pix = 0;
    int   fd_seen  = 0;
    exp_t q[$];

    gaussian_filter_5x5 #(.ROWS(7), .COLS(7)) dut (
        .clk(clk), .rst(rst),
        .d0_i(win[0]),   .d1_i(win[1]),   .d2_i(win[2]),   .d3_i(win[3]),   .d4_i(win[4]),
        .d5_i(win[5]),   .d6_i(win[6]),   .d7_i(win[7]),   .d8_i(win[8]),   .d9_i(win[9]),
        .d10_i(win[10]), .d11_i(win[11]), .d12_i(win[12]), .d13_i(win[13]), .d14_i(win[14]),
        .d15_i(win[15]), .d16_i(win[16]), .d17_i(win[17]), .d18_i(win[18]), .d19_i(win[19]),
        .d20_i(win[20]), .d21_i(win[21]), .d22_i(win[22]), .d23_i(win[23]), .d24_i(win[24]),
        .done_i(done_i),
        .pixel_o(pixel_o),
        .done_o(done_o),
        .frame_done_o(frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: direct 2-D weighted sum with the full 5x5 kernel.
    function automatic int model(input win_t w);
        int k[5] = '{1, 4, 6, 4, 1};
        int s = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s += k[r] * k[c] * int'(w[5*r + c]);
`ifdef GAUSS_ROUND_EN
        return (s + 128) / 256;
`else
        return s / 256;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic rand_win();
        for (int i = 0; i < 25; i++) win[i] = 8'($urandom_range(0, 255));
    endtask

    // Compare the DUT outputs against the oldest pending expectation.
    task automatic check_out();
        exp_t e;
        int   exp_fd;
        e = q.pop_front();
        exp_fd = 0;
        if (e.vld) begin
            last_pix = e.pix;
            exp_fd   = (out_cnt == FRAME - 1) ? 1 : 0;
            out_cnt  = (out_cnt + 1) % FRAME;
        end
        check("done_o", int'(done_o), int'(e.vld));
        check("pixel_o", int'(pixel_o), last_pix);
        check("frame_done_o", int'(frame_done_o), exp_fd);
        if (frame_done_o) fd_seen++;
    endtask

    // Drive n random windows (every cycle, or alternating with bubbles);
    // outputs are compared three cycles after the matching input.
    task automatic stream(input int n, input bit alt, input bit flush);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (q.size() == 3) check_out();
            rand_win();
            done_i = alt ? ((j % 2) == 0) : 1'b1;
            e.vld = done_i;
            e.pix = model(win);
            q.push_back(e);
        end
        if (flush) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check_out();
                done_i = 1'b0;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        done_i = 1'b0;
        @(negedge clk);
        check("reset done_o", int'(done_o), 0);
        check("reset pixel_o", int'(pixel_o), 0);
        check("reset frame_done_o", int'(frame_done_o), 0);
        rst = 1'b1;
        q.delete();
        out_cnt  = 0;
        last_pix = 0;
        fd_seen  = 0;
    endtask

    vec_t vecs[6];

    initial begin
`ifdef GAUSS_ROUND_EN
        vecs[0] = '{100, -1,   0, 100, "uniform100"};
        vecs[1] = '{  0, 12, 255,  36, "impulse_centre"};
        vecs[2] = '{  0,  0, 255,   1, "corner_d0"};
        vecs[3] = '{255, -1,   0, 255, "all255"};
        vecs[4] = '{  0,  2, 255,   6, "top_mid_d2"};
        vecs[5] = '{  0, 24, 255,   1, "corner_d24"};
`else
        vecs[0] = '{100, -1,   0, 100, "uniform100"};
        vecs[1] = '{  0, 12, 255,  35, "impulse_centre"};
        vecs[2] = '{  0,  0, 255,   0, "corner_d0"};
        vecs[3] = '{255, -1,   0, 255, "all255"};
        vecs[4] = '{  0,  2, 255,   5, "top_mid_d2"};
        vecs[5] = '{  0, 24, 255,   0, "corner_d24"};
`endif
        rst = 1'b0;
        done_i = 1'b0;
        for (int i = 0; i < 25; i++) win[i] = 8'd0;
        repeat (2) @(negedge clk);
        check("por done_o", int'(done_o), 0);
        check("por pixel_o", int'(pixel_o), 0);
        check("por frame_done_o", int'(frame_done_o), 0);
        rst = 1'b1;

        // Directed windows: single pulse, exact 3-cycle latency, then hold.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            for (int i = 0; i < 25; i++) win[i] = 8'(vecs[v].fill);
            if (vecs[v].poke_idx >= 0) win[vecs[v].poke_idx] = 8'(vecs[v].poke_val);
            done_i = 1'b1;
            @(negedge clk);
            done_i = 1'b0;
            rand_win();
            check({vecs[v].name, " lat1 done_o"}, int'(done_o), 0);
            @(negedge clk);
            check({vecs[v].name, " lat2 done_o"}, int'(done_o), 0);
            @(negedge clk);
            check({vecs[v].name, " done_o"}, int'(done_o), 1);
            check({vecs[v].name, " pixel_o"}, int'(pixel_o), vecs[v].exp_pix);
            check({vecs[v].name, " frame_done_o"}, int'(frame_done_o), 0);
            @(negedge clk);
            check({vecs[v].name, " done_o drop"}, int'(done_o), 0);
            check({vecs[v].name, " pixel_o hold"}, int'(pixel_o), vecs[v].exp_pix);
            $display("vector %s: pixel_o=%0d", vecs[v].name, pixel_o);
        end

        // Two full frames back to back.
        reset_dut();
        stream(2 * FRAME, 1'b0, 1'b1);
        check("two frames frame_done count", fd_seen, 2);
        check("two frames counter wrapped", out_cnt, 0);
        $display("two frames: frame_done pulses=%0d", fd_seen);

        // Alternating valid/bubble with random windows.
        stream(30, 1'b1, 1'b1);
        $display("alternating stream: outputs so far=%0d", out_cnt);

        // Asynchronous reset mid-frame, mid-pipeline.
        reset_dut();
        stream(23, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        done_i = 1'b0;
        #1;
        check("async rst done_o", int'(done_o), 0);
        check("async rst pixel_o", int'(pixel_o), 0);
        check("async rst frame_done_o", int'(frame_done_o), 0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        out_cnt  = 0;
        last_pix = 0;
        fd_seen  = 0;
        stream(FRAME, 1'b0, 1'b1);
        check("post-reset frame_done count", fd_seen, 1);
        $display("post-reset frame: frame_done pulses=%0d", fd_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
